axis_pipe_reg: RTL and testbench

// - LENGTH-deep chain of AXI4-Stream register slices, used to break long timing paths between AXIS blocks.
// - REG_TYPE selects the slice type for every stage: bypass, simple (bubble) or skid (full rate).
// - Adds an occupancy count. Sidebands are carried only when enabled; disabled sidebands are driven to constants.

---
 rtl/axis_pipe_reg.sv | 183 ++++++++++++++++++
 tb/tb_axis_pipe_reg.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pipe_reg.sv
// rtl/axis_pipe_reg.sv - LENGTH-deep chain of AXI4-Stream register slices with occupancy count
// Disabled sidebands are zeroed on entry so their flops are constant and drop out in synthesis.
module axis_pipe_reg #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter bit LAST_ENABLE = 1'b1,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b0,
  parameter int USER_WIDTH  = 1,
  parameter int REG_TYPE    = 2,
  parameter int LENGTH      = 2,
  parameter int CNT_WIDTH   = $clog2(2 * LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  localparam int KO = DATA_WIDTH;
  localparam int LO = KO + KEEP_WIDTH;
  localparam int IO = LO + 1;
  localparam int DO = IO + ID_WIDTH;
  localparam int UO = DO + DEST_WIDTH;
  localparam int PW = UO + USER_WIDTH;

  logic [PW-1:0] s_pay;
  logic [PW-1:0] m_pay;

  assign s_pay = {USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}},
                  DEST_ENABLE ? s_axis_tdest : {DEST_WIDTH{1'b0}},
                  ID_ENABLE   ? s_axis_tid   : {ID_WIDTH{1'b0}},
                  LAST_ENABLE ? s_axis_tlast : 1'b0,
                  KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b0}},
                  s_axis_tdata};

  assign m_axis_tdata = m_pay[DATA_WIDTH-1:0];
  assign m_axis_tkeep = KEEP_ENABLE ? m_pay[LO-1:KO] : {KEEP_WIDTH{1'b1}};
  assign m_axis_tlast = LAST_ENABLE ? m_pay[LO] : 1'b1;
  assign m_axis_tid   = ID_ENABLE   ? m_pay[DO-1:IO] : {ID_WIDTH{1'b0}};
  assign m_axis_tdest = DEST_ENABLE ? m_pay[UO-1:DO] : {DEST_WIDTH{1'b0}};
  assign m_axis_tuser = USER_ENABLE ? m_pay[PW-1:UO] : {USER_WIDTH{1'b0}};

  generate
    if (REG_TYPE == 0) begin : g_bypass
      assign s_axis_tready = m_axis_tready;
      assign m_axis_tvalid = s_axis_tvalid;
      assign m_pay         = s_pay;
      assign occupancy     = '0;
    end else begin : g_chain
      // Index 0 is the slave side of the chain, index LENGTH the master side.
      logic [LENGTH:0] c_vld;
      logic [LENGTH:0] c_rdy;
      logic [PW-1:0]   c_pay [LENGTH+1];
      logic [CNT_WIDTH-1:0] occ_d, occ_q;
      logic in_fire, out_fire;

      assign c_vld[0]      = s_axis_tvalid;
      assign c_pay[0]      = s_pay;
      assign s_axis_tready = c_rdy[0];
      assign c_rdy[LENGTH] = m_axis_tready;
      assign m_axis_tvalid = c_vld[LENGTH];
      assign m_pay         = c_pay[LENGTH];

      for (genvar i = 0; i < LENGTH; i++) begin : g_stage
        if (REG_TYPE == 1) begin : g_simple
          logic vld_d, vld_q, rdy_d, rdy_q;
          logic [PW-1:0] pay_d, pay_q;

          always_comb begin
            vld_d = vld_q;
            pay_d = pay_q;
            if (vld_q && c_rdy[i+1]) vld_d = 1'b0;
            if (c_vld[i] && rdy_q) begin
              vld_d = 1'b1;
              pay_d = c_pay[i];
            end
            rdy_d = !vld_d;
          end

          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              vld_q <= 1'b0;
              rdy_q <= 1'b0;
              pay_q <= '0;
            end else begin
              vld_q <= vld_d;
              rdy_q <= rdy_d;
              pay_q <= pay_d;
            end
          end

          assign c_vld[i+1] = vld_q;
          assign c_pay[i+1] = pay_q;
          assign c_rdy[i]   = rdy_q;
        end else begin : g_skid
          logic out_vld_d, out_vld_q, skid_vld_d, skid_vld_q, rdy_d, rdy_q;
          logic [PW-1:0] out_pay_d, out_pay_q, skid_pay_d, skid_pay_q;

          // Ready is low whenever the skid holds a beat, so it always drains before new input.
          always_comb begin
            out_vld_d  = out_vld_q;
            out_pay_d  = out_pay_q;
            skid_vld_d = skid_vld_q;
            skid_pay_d = skid_pay_q;
            if (c_rdy[i+1] || !out_vld_q) begin
              if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_pay_d  = skid_pay_q;
                skid_vld_d = 1'b0;
              end else if (c_vld[i] && rdy_q) begin
                out_vld_d = 1'b1;
                out_pay_d = c_pay[i];
              end else begin
                out_vld_d = 1'b0;
              end
            end else if (c_vld[i] && rdy_q) begin
              skid_vld_d = 1'b1;
              skid_pay_d = c_pay[i];
            end
            rdy_d = !skid_vld_d;
          end

          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              out_vld_q  <= 1'b0;
              out_pay_q  <= '0;
              skid_vld_q <= 1'b0;
              skid_pay_q <= '0;
              rdy_q      <= 1'b0;
            end else begin
              out_vld_q  <= out_vld_d;
              out_pay_q  <= out_pay_d;
              skid_vld_q <= skid_vld_d;
              skid_pay_q <= skid_pay_d;
              rdy_q      <= rdy_d;
            end
          end

          assign c_vld[i+1] = out_vld_q;
          assign c_pay[i+1] = out_pay_q;
          assign c_rdy[i]   = rdy_q;
        end
      end

      assign in_fire  = s_axis_tvalid && s_axis_tready;
      assign out_fire = m_axis_tvalid && m_axis_tready;

      always_comb begin
        occ_d = occ_q;
        if (in_fire && !out_fire)      occ_d = occ_q + CNT_WIDTH'(1);
        else if (!in_fire && out_fire) occ_d = occ_q - CNT_WIDTH'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
      end

      assign occupancy = occ_q;
    end
  endgenerate

endmodule

// File: tb/tb_axis_pipe_reg.sv
// tb/tb_axis_pipe_reg.sv - directed and scoreboarded bench for axis_pipe_reg
module tb_axis_pipe_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // shared idle sidebands for the 8-bit instances
  logic       z_last = 1'b0;
  logic [0:0] z_keep = 1'b0;
  logic [7:0] z_id = 8'h0, z_dest = 8'h0;
  logic [0:0] z_user = 1'b0;

  // a: 32-bit skid, LENGTH 2, sidebands on
  logic [31:0] a_s_tdata = '0, a_m_tdata;
  logic a_s_tvalid = 1'b0, a_s_tready, a_s_tlast = 1'b0, a_m_tvalid, a_m_tready = 1'b0, a_m_tlast;
  logic [3:0] a_s_tkeep = '0, a_m_tkeep;
  logic [7:0] a_s_tid = '0, a_m_tid, a_m_tdest;
  logic [0:0] a_s_tuser = '0, a_m_tuser;
  logic [2:0] a_occ;

  axis_pipe_reg #(.DATA_WIDTH(32), .KEEP_ENABLE(1), .LAST_ENABLE(1), .ID_ENABLE(1),
                  .USER_ENABLE(1), .REG_TYPE(2), .LENGTH(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .s_axis_tlast(a_s_tlast), .s_axis_tkeep(a_s_tkeep), .s_axis_tid(a_s_tid),
    .s_axis_tdest(z_dest), .s_axis_tuser(a_s_tuser),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .m_axis_tlast(a_m_tlast), .m_axis_tkeep(a_m_tkeep), .m_axis_tid(a_m_tid),
    .m_axis_tdest(a_m_tdest), .m_axis_tuser(a_m_tuser), .occupancy(a_occ));

  // b: simple, LENGTH 1
  logic [7:0] b_s_tdata = '0, b_m_tdata, b_m_tid, b_m_tdest;
  logic b_s_tvalid = 1'b0, b_s_tready, b_m_tvalid, b_m_tready = 1'b0, b_m_tlast;
  logic [0:0] b_m_tkeep, b_m_tuser;
  logic [1:0] b_occ;

  axis_pipe_reg #(.REG_TYPE(1), .LENGTH(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .s_axis_tlast(z_last), .s_axis_tkeep(z_keep), .s_axis_tid(z_id),
    .s_axis_tdest(z_dest), .s_axis_tuser(z_user),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .m_axis_tlast(b_m_tlast), .m_axis_tkeep(b_m_tkeep), .m_axis_tid(b_m_tid),
    .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser), .occupancy(b_occ));

  // c: skid, LENGTH 3
  logic [7:0] c_s_tdata = '0, c_m_tdata, c_m_tid, c_m_tdest;
  logic c_s_tvalid = 1'b0, c_s_tready, c_m_tvalid, c_m_tready = 1'b0, c_m_tlast;
  logic [0:0] c_m_tkeep, c_m_tuser;
  logic [2:0] c_occ;

  axis_pipe_reg #(.REG_TYPE(2), .LENGTH(3)) u_c (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(c_s_tdata), .s_axis_tvalid(c_s_tvalid), .s_axis_tready(c_s_tready),
    .s_axis_tlast(z_last), .s_axis_tkeep(z_keep), .s_axis_tid(z_id),
    .s_axis_tdest(z_dest), .s_axis_tuser(z_user),
    .m_axis_tdata(c_m_tdata), .m_axis_tvalid(c_m_tvalid), .m_axis_tready(c_m_tready),
    .m_axis_tlast(c_m_tlast), .m_axis_tkeep(c_m_tkeep), .m_axis_tid(c_m_tid),
    .m_axis_tdest(c_m_tdest), .m_axis_tuser(c_m_tuser), .occupancy(c_occ));

  // d: 16-bit, keep/last/id disabled
  logic [15:0] d_s_tdata = '0, d_m_tdata;
  logic d_s_tvalid = 1'b0, d_s_tready, d_s_tlast = 1'b0, d_m_tvalid, d_m_tready = 1'b0, d_m_tlast;
  logic [1:0] d_s_tkeep = '0, d_m_tkeep;
  logic [7:0] d_s_tid = '0, d_m_tid, d_m_tdest;
  logic [0:0] d_m_tuser;
  logic [2:0] d_occ;

  axis_pipe_reg #(.DATA_WIDTH(16), .KEEP_ENABLE(0), .LAST_ENABLE(0), .ID_ENABLE(0),
                  .REG_TYPE(2), .LENGTH(2)) u_d (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(d_s_tdata), .s_axis_tvalid(d_s_tvalid), .s_axis_tready(d_s_tready),
    .s_axis_tlast(d_s_tlast), .s_axis_tkeep(d_s_tkeep), .s_axis_tid(d_s_tid),
    .s_axis_tdest(z_dest), .s_axis_tuser(z_user),
    .m_axis_tdata(d_m_tdata), .m_axis_tvalid(d_m_tvalid), .m_axis_tready(d_m_tready),
    .m_axis_tlast(d_m_tlast), .m_axis_tkeep(d_m_tkeep), .m_axis_tid(d_m_tid),
    .m_axis_tdest(d_m_tdest), .m_axis_tuser(d_m_tuser), .occupancy(d_occ));

  // e: bypass
  logic [7:0] e_s_tdata = '0, e_m_tdata, e_m_tid, e_m_tdest;
  logic e_s_tvalid = 1'b0, e_s_tready, e_s_tlast = 1'b1, e_m_tvalid, e_m_tready = 1'b0, e_m_tlast;
  logic [0:0] e_m_tkeep, e_m_tuser;
  logic [2:0] e_occ;

  axis_pipe_reg #(.REG_TYPE(0), .LENGTH(2)) u_e (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(e_s_tdata), .s_axis_tvalid(e_s_tvalid), .s_axis_tready(e_s_tready),
    .s_axis_tlast(e_s_tlast), .s_axis_tkeep(z_keep), .s_axis_tid(z_id),
    .s_axis_tdest(z_dest), .s_axis_tuser(z_user),
    .m_axis_tdata(e_m_tdata), .m_axis_tvalid(e_m_tvalid), .m_axis_tready(e_m_tready),
    .m_axis_tlast(e_m_tlast), .m_axis_tkeep(e_m_tkeep), .m_axis_tid(e_m_tid),
    .m_axis_tdest(e_m_tdest), .m_axis_tuser(e_m_tuser), .occupancy(e_occ));

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, recv, cyc;
    logic acc;
    logic [63:0] q[$];
    logic [63:0] exp_beat;

    // reset state
    @(negedge clk); #1;
    check("rst_a_vld", a_m_tvalid, 0);
    check("rst_a_occ", a_occ, 0);
    check("rst_a_data", a_m_tdata, 0);
    check("rst_a_rdy", a_s_tready, 0);
    check("rst_b_rdy", b_s_tready, 0);
    check("rst_c_rdy", c_s_tready, 0);
    check("rst_d_keep", d_m_tkeep, 2'b11);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_a_rdy_low", a_s_tready, 0);
    @(negedge clk); #1;
    check("rel_a_rdy_high", a_s_tready, 1);
    check("rel_b_rdy_high", b_s_tready, 1);

    // throughput: 16 back-to-back beats through a 2-stage skid chain
    a_m_tready = 1'b1; sent = 0; recv = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_s_tvalid = (sent < 16);
      a_s_tdata = 32'(sent);
      #1;
      if (c < 2) check("thru_vld_lat", a_m_tvalid, 0);
      if (c >= 2 && c <= 16) check("thru_occ", a_occ, 2);
      if (c >= 2 && c <= 17) begin
        check("thru_vld", a_m_tvalid, 1);
        check("thru_data", a_m_tdata, 64'(c - 2));
      end
      if (c < 16) check("thru_rdy", a_s_tready, 1);
      if (a_s_tvalid && a_s_tready) sent++;
      if (a_m_tvalid && a_m_tready) recv++;
    end
    check("thru_cnt", recv, 16);

    // rate: simple slice accepts every other cycle
    b_m_tready = 1'b1; sent = 0; recv = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      b_s_tvalid = (sent < 8);
      b_s_tdata = 8'h40 + 8'(sent);
      #1;
      check("rate_rdy", b_s_tready, (c % 2 == 0));
      if (b_m_tvalid) check("rate_data", b_m_tdata, 8'h40 + 8'(recv));
      if (b_s_tvalid && b_s_tready) sent++;
      if (b_m_tvalid && b_m_tready) recv++;
    end
    check("rate_sent", sent, 8);
    check("rate_recv", recv, 8);
    b_s_tvalid = 1'b0;

    // back-pressure: 3-stage skid chain fills to 6
    c_m_tready = 1'b0; sent = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      c_s_tvalid = 1'b1;
      c_s_tdata = 8'h10 + 8'(sent);
      #1;
      if (c_s_tvalid && c_s_tready) sent++;
    end
    check("bp_sent", sent, 6);
    check("bp_occ", c_occ, 6);
    check("bp_rdy", c_s_tready, 0);
    check("bp_head", c_m_tdata, 8'h10);
    @(negedge clk);
    c_s_tvalid = 1'b0; c_m_tready = 1'b1; recv = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c_m_tvalid && c_m_tready) begin
        check("bp_drain", c_m_tdata, 8'h10 + 8'(recv));
        recv++;
      end
      @(negedge clk);
    end
    check("bp_recv", recv, 6);
    check("bp_occ_end", c_occ, 0);

    // random stress with scoreboard
    sent = 0; recv = 0; cyc = 0; acc = 1'b0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      if (acc) a_s_tvalid = 1'b0;
      if (!a_s_tvalid && sent < 1000 && $urandom_range(1) == 1) begin
        a_s_tvalid = 1'b1;
        a_s_tdata = $urandom;
        a_s_tkeep = 4'($urandom);
        a_s_tlast = 1'($urandom);
        a_s_tid = 8'($urandom);
        a_s_tuser = 1'($urandom);
      end
      a_m_tready = 1'($urandom_range(1));
      #1;
      check("st_occ", a_occ, 64'(q.size()));
      check("st_occ_max", a_occ <= 3'd4, 1);
      acc = a_s_tvalid && a_s_tready;
      if (acc) begin
        q.push_back({a_s_tuser, a_s_tid, a_s_tlast, a_s_tkeep, a_s_tdata});
        sent++;
      end
      if (a_m_tvalid && a_m_tready) begin
        exp_beat = (q.size() > 0) ? q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check("st_beat", {a_m_tuser, a_m_tid, a_m_tlast, a_m_tkeep, a_m_tdata}, exp_beat);
        recv++;
      end
      cyc++;
    end
    check("st_done", recv, 1000);
    @(negedge clk);
    a_s_tvalid = 1'b0; a_m_tready = 1'b0;

    // reset mid-stream with 3 beats held
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_s_tvalid = (sent < 3);
      a_s_tdata = 32'hDEAD_0000 + 32'(sent);
      #1;
      if (a_s_tvalid && a_s_tready) sent++;
    end
    check("mid_sent", sent, 3);
    check("mid_occ", a_occ, 3);
    check("mid_vld", a_m_tvalid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", a_m_tvalid, 0);
    check("mid_rst_occ", a_occ, 0);
    check("mid_rst_data", a_m_tdata, 0);
    check("mid_rst_rdy", a_s_tready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; a_m_tready = 1'b1;
    #1;
    check("mid_rel_rdy", a_s_tready, 0);
    recv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_s_tvalid = (c == 0);
      a_s_tdata = 32'h0000_A5A5;
      #1;
      if (c == 0) check("mid_new_rdy", a_s_tready, 1);
      if (a_m_tvalid && a_m_tready) begin
        check("mid_new_data", a_m_tdata, 32'h0000_A5A5);
        recv++;
      end
    end
    check("mid_new_cnt", recv, 1);

    // disabled sidebands drive constants
    d_m_tready = 1'b1; sent = 0; recv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      d_s_tvalid = (sent < 8);
      d_s_tdata = 16'h1200 + 16'(sent);
      d_s_tid = 8'($urandom);
      d_s_tlast = 1'($urandom);
      d_s_tkeep = 2'($urandom);
      #1;
      if (d_m_tvalid && d_m_tready) begin
        check("dis_data", d_m_tdata, 16'h1200 + 16'(recv));
        check("dis_tid", d_m_tid, 0);
        check("dis_tlast", d_m_tlast, 1);
        check("dis_tkeep", d_m_tkeep, 2'b11);
        recv++;
      end
      if (d_s_tvalid && d_s_tready) sent++;
    end
    check("dis_recv", recv, 8);
    d_s_tvalid = 1'b0;

    // bypass is pure wiring
    @(negedge clk);
    e_s_tvalid = 1'b1; e_s_tdata = 8'h3C; e_s_tlast = 1'b0; e_m_tready = 1'b0;
    #1;
    check("byp_rdy0", e_s_tready, 0);
    check("byp_vld", e_m_tvalid, 1);
    check("byp_data", e_m_tdata, 8'h3C);
    check("byp_last", e_m_tlast, 0);
    check("byp_occ", e_occ, 0);
    e_m_tready = 1'b1;
    #1;
    check("byp_rdy1", e_s_tready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
